// File: rtl/attn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : attn_ctrl_pkg
//  Brief   : Shared types for the attention stage sequencer: FSM state
//            encoding, error codes and a stage-index width helper.
//  Revision: 1.0  initial release
// ============================================================================
package attn_ctrl_pkg;

    // Sequencer states. The width is fixed so the encoding is stable across tools.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Reason a run ended with error set.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ABORT   = 2'd2
    } err_code_t;

    // Width of a stage index; a single-stage build still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/attn_next_stage.sv
`default_nettype none
// ============================================================================
//  Module  : attn_next_stage
//  Brief   : Priority encoder returning the lowest enabled stage index above
//            the current one (or from the very first stage when i_from_start
//            is set), plus a flag when no enabled stage remains.
//  Revision: 1.0  initial release
// ============================================================================
module attn_next_stage
    import attn_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3
)(
    input  logic [NUM_STAGES-1:0]            i_mask,
    input  logic [idx_width(NUM_STAGES)-1:0] i_cur_idx,
    input  logic                             i_from_start,
    output logic [idx_width(NUM_STAGES)-1:0] o_next_idx,
    output logic                             o_none_left
);

    localparam int IDX_W = idx_width(NUM_STAGES);

    // Scan from the top down so the lowest qualifying index is the last write.
    always_comb begin
        o_next_idx  = '0;
        o_none_left = 1'b1;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_from_start || (i > int'(i_cur_idx)))) begin
                o_next_idx  = IDX_W'(i);
                o_none_left = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/attn_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : attn_stage_sequencer
//  Brief   : Launches the attention compute stages one at a time over
//            start/done pulse handshakes, with stage masking, a per-stage
//            timeout watchdog, abort, error reporting and a run-length counter.
//            All outputs come from registers or from a decode of the state.
//  Revision: 1.0  initial release
// ============================================================================
module attn_stage_sequencer
    import attn_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int TMO_W      = 24,
    parameter int CNT_W      = 32
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_STAGES-1:0]            stage_mask,
    input  logic [TMO_W-1:0]                 timeout_lim,
    input  logic                             abort,
    input  logic [NUM_STAGES-1:0]            stage_done,
    output logic [NUM_STAGES-1:0]            stage_start,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic [idx_width(NUM_STAGES)-1:0] err_stage,
    output logic [idx_width(NUM_STAGES)-1:0] cur_stage,
    output logic [CNT_W-1:0]                 run_cycles
);

    localparam int IDX_W = idx_width(NUM_STAGES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_STAGES-1:0]   r_mask;
    logic [TMO_W-1:0]        r_lim;
    logic [IDX_W-1:0]        r_cur;
    logic [TMO_W-1:0]        r_wait;
    logic                    r_error;
    err_code_t               r_code;
    err_code_t               w_code_nxt;
    logic [IDX_W-1:0]        r_estage;
    logic [CNT_W-1:0]        r_run;

    logic                    w_accept;
    logic                    w_enc_from_start;
    logic [NUM_STAGES-1:0]   w_enc_mask;
    logic [IDX_W-1:0]        w_next_idx;
    logic                    w_none_left;
    logic [TMO_W-1:0]        w_wait_inc;
    logic                    w_cur_done;
    logic                    w_timeout;
    logic                    w_enter_err;

    // In IDLE the encoder looks at the live mask from the first stage on;
    // afterwards it walks the latched mask above the current stage.
    assign w_enc_from_start = (r_state == ST_IDLE);
    assign w_enc_mask       = w_enc_from_start ? stage_mask : r_mask;

    attn_next_stage #(
        .NUM_STAGES (NUM_STAGES)
    ) u_next_stage (
        .i_mask       (w_enc_mask),
        .i_cur_idx    (r_cur),
        .i_from_start (w_enc_from_start),
        .o_next_idx   (w_next_idx),
        .o_none_left  (w_none_left)
    );

    // Handshake qualifiers: only the current stage's done bit is looked at, and
    // the timeout compares the count including the present WAIT cycle.
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && start;
        w_wait_inc = (&r_wait) ? r_wait : (r_wait + TMO_W'(1));
        w_cur_done = stage_done[r_cur];
        w_timeout  = (r_lim != '0) && (w_wait_inc >= r_lim);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks done, and done outranks timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = ERR_NONE;
        w_enter_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_none_left ? ST_FINISH : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    w_state_nxt = ST_ERROR;
                    w_code_nxt  = ERR_ABORT;
                    w_enter_err = 1'b1;
                end else if (w_cur_done) begin
                    w_state_nxt = ST_NEXT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERROR;
                    w_code_nxt  = ERR_TIMEOUT;
                    w_enter_err = 1'b1;
                end
            end
            ST_NEXT: begin
                w_state_nxt = w_none_left ? ST_FINISH : ST_LAUNCH;
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Run configuration and stage pointer, captured when a run is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_lim  <= '0;
            r_cur  <= '0;
        end else if (w_accept) begin
            r_mask <= stage_mask;
            r_lim  <= timeout_lim;
            r_cur  <= w_next_idx;
        end else if ((r_state == ST_NEXT) && !w_none_left) begin
            r_cur  <= w_next_idx;
        end
    end

    // Per-stage wait counter: zeroed at launch, saturating while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_wait <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait <= w_wait_inc;
        end
    end

    // Error status: cleared on accept, loaded on the way into ERROR, else held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error  <= 1'b0;
            r_code   <= ERR_NONE;
            r_estage <= '0;
        end else if (w_accept) begin
            r_error  <= 1'b0;
            r_code   <= ERR_NONE;
            r_estage <= '0;
        end else if (w_enter_err) begin
            r_error  <= 1'b1;
            r_code   <= w_code_nxt;
            r_estage <= r_cur;
        end
    end

    // Run-length counter: counts every non-IDLE cycle and sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= '0;
        end else if (w_accept) begin
            r_run <= '0;
        end else if ((r_state != ST_IDLE) && !(&r_run)) begin
            r_run <= r_run + CNT_W'(1);
        end
    end

    // Moore output decode.
    always_comb begin
        stage_start = '0;
        if (r_state == ST_LAUNCH) begin
            stage_start[r_cur] = 1'b1;
        end
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_FINISH) || (r_state == ST_ERROR);
        error      = r_error;
        err_code   = r_code;
        err_stage  = r_estage;
        cur_stage  = r_cur;
        run_cycles = r_run;
    end

endmodule
`default_nettype wire

// File: tb/tb_attn_stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_attn_stage_sequencer
//  Brief   : Self-checking bench. Each run is first planned as a timeline of
//            expected events (launch cycles, done cycle, error outcome) from
//            the stage latencies, limit and abort time; a compare process then
//            checks every output against that timeline each cycle.
//  Revision: 1.0  initial release
// ============================================================================
module tb_attn_stage_sequencer;
    import attn_ctrl_pkg::*;

    localparam int NS    = 3;
    localparam int TMO_W = 24;
    localparam int CNT_W = 32;
    localparam int MAXC  = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NS-1:0]    stage_mask;
    logic [TMO_W-1:0] timeout_lim;
    logic             abort;
    logic [NS-1:0]    stage_done;
    logic [NS-1:0]    stage_start;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [1:0]       err_stage;
    logic [1:0]       cur_stage;
    logic [CNT_W-1:0] run_cycles;

    attn_stage_sequencer #(
        .NUM_STAGES (NS),
        .TMO_W      (TMO_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stage_mask  (stage_mask),
        .timeout_lim (timeout_lim),
        .abort       (abort),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .err_stage   (err_stage),
        .cur_stage   (cur_stage),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Planned timeline of the current run; cycle 0 is the cycle carrying start.
    int          e_end;
    logic [2:0]  e_start [MAXC];
    int          e_wstage[MAXC];
    logic [2:0]  e_ddone [MAXC];
    logic        e_abort [MAXC];
    logic        e_err;
    logic [1:0]  e_code;
    logic [1:0]  e_estage;

    // Values the DUT must be holding between runs.
    logic        m_err;
    logic [1:0]  m_code;
    logic [1:0]  m_estage;
    logic [31:0] m_run;

    // Expectations for the cycle in progress.
    logic        chk_en;
    logic [2:0]  x_start;
    logic        x_busy, x_done, x_err;
    logic [1:0]  x_code, x_estage;
    logic [31:0] x_run;
    int          x_cur;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle compare against the planned timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stage_start", 64'(stage_start), 64'(x_start));
            check("busy",        64'(busy),        64'(x_busy));
            check("done",        64'(done),        64'(x_done));
            check("error",       64'(error),       64'(x_err));
            check("err_code",    64'(err_code),    64'(x_code));
            check("err_stage",   64'(err_stage),   64'(x_estage));
            check("run_cycles",  64'(run_cycles),  64'(x_run));
            if (x_cur >= 0) check("cur_stage", 64'(cur_stage), 64'(x_cur));
        end
    end

    // Walk the enabled stages in order: a stage costs a launch cycle, then
    // WAIT cycles until its done (or abort/timeout), then a NEXT cycle.
    task automatic plan(input logic [2:0] mask, input int lim,
                        input int lat0, input int lat1, input int lat2, input int abort_at);
        int  lat[3];
        int  t;
        int  w;
        bit  stop;
        lat[0] = lat0; lat[1] = lat1; lat[2] = lat2;
        for (int c = 0; c < MAXC; c++) begin
            e_start[c] = '0; e_wstage[c] = -1; e_ddone[c] = '0; e_abort[c] = 1'b0;
        end
        e_err = 1'b0; e_code = 2'd0; e_estage = 2'd0;
        stop = 1'b0;
        t = 1;
        for (int s = 0; s < NS; s++) begin
            if (!stop && mask[s]) begin
                e_start[t][s] = 1'b1;
                for (int n = 1; n < 100; n++) begin
                    w = t + n;
                    e_wstage[w] = s;
                    if (lat[s] == n) e_ddone[w][s] = 1'b1;
                    if (w == abort_at) begin
                        e_abort[w] = 1'b1;
                        e_err = 1'b1; e_code = 2'd2; e_estage = s[1:0];
                        t = w + 1; stop = 1'b1;
                        break;
                    end
                    if (lat[s] == n) begin
                        t = w + 2;
                        break;
                    end
                    if (lim != 0 && n >= lim) begin
                        e_err = 1'b1; e_code = 2'd1; e_estage = s[1:0];
                        t = w + 1; stop = 1'b1;
                        break;
                    end
                end
            end
        end
        e_end = t;
    endtask

    task automatic set_idle();
        start = 1'b0; abort = 1'b0; stage_done = '0;
        x_start = '0; x_busy = 1'b0; x_done = 1'b0;
        x_err = m_err; x_code = m_code; x_estage = m_estage; x_run = m_run; x_cur = -1;
    endtask

    // Drive inputs and set expectations for cycle c of the planned run.
    task automatic drive_cycle(input int c, input logic [2:0] mask, input int lim, input bit noise);
        logic [2:0] dv;
        start       = (c == 0) || (noise && c >= 1 && c <= e_end && $urandom_range(0, 3) == 0);
        stage_mask  = (c == 0) ? mask : 3'($urandom);
        timeout_lim = (c == 0) ? 24'(lim) : 24'($urandom);
        dv = (c <= e_end) ? e_ddone[c] : 3'b000;
        if (noise) begin
            for (int j = 0; j < NS; j++)
                if (e_wstage[c] != j && $urandom_range(0, 4) == 0) dv[j] = 1'b1;
        end
        stage_done = dv;
        abort = e_abort[c] || (noise && c > e_end && $urandom_range(0, 1) == 1);

        x_start = (c <= e_end) ? e_start[c] : 3'b000;
        x_busy  = (c >= 1) && (c <= e_end);
        x_done  = (c == e_end);
        if (c == 0) begin
            x_err = m_err; x_code = m_code; x_estage = m_estage; x_run = m_run;
        end else if (c < e_end) begin
            x_err = 1'b0; x_code = 2'd0; x_estage = 2'd0; x_run = 32'(c - 1);
        end else begin
            x_err = e_err; x_code = e_code; x_estage = e_err ? e_estage : 2'd0;
            x_run = (c == e_end) ? 32'(c - 1) : 32'(e_end);
        end
        x_cur = -1;
        if (c <= e_end) begin
            if (e_wstage[c] >= 0) x_cur = e_wstage[c];
            for (int s = 0; s < NS; s++) if (e_start[c][s]) x_cur = s;
        end
    endtask

    task automatic run_one(input logic [2:0] mask, input int lim,
                           input int lat0, input int lat1, input int lat2,
                           input int abort_at, input bit noise, input int gap);
        plan(mask, lim, lat0, lat1, lat2, abort_at);
        for (int c = 0; c <= e_end + gap; c++) begin
            drive_cycle(c, mask, lim, noise);
            @(posedge clk); #1;
        end
        m_err = e_err; m_code = e_code; m_estage = e_err ? e_estage : 2'd0; m_run = 32'(e_end);
        set_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m_err = 1'b0; m_code = 2'd0; m_estage = 2'd0; m_run = 32'd0;
        stage_mask = '0; timeout_lim = '0;
        set_idle();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Three stages, five-cycle latency each.
        run_one(3'b111, 0, 5, 5, 5, -1, 1'b0, 2);
        check("t1_run_cycles", 64'(run_cycles), 64'd22);
        check("t1_error",      64'(error),      64'd0);

        // Middle stage masked off, then an empty mask.
        run_one(3'b101, 0, 5, 5, 5, -1, 1'b0, 1);
        check("t2_run_cycles", 64'(run_cycles), 64'd15);
        run_one(3'b000, 0, 5, 5, 5, -1, 1'b0, 1);
        check("t2_empty_run_cycles", 64'(run_cycles), 64'd1);

        // Silent stage 1 trips the watchdog; done on the limit cycle does not.
        run_one(3'b111, 10, 5, 0, 5, -1, 1'b0, 1);
        check("t3_error",     64'(error),     64'd1);
        check("t3_err_code",  64'(err_code),  64'd1);
        check("t3_err_stage", 64'(err_stage), 64'd1);
        run_one(3'b111, 10, 5, 10, 5, -1, 1'b0, 1);
        check("t3b_error",      64'(error),      64'd0);
        check("t3b_run_cycles", 64'(run_cycles), 64'd27);

        // Abort coincident with stage 0 done, with stray done/start noise,
        // then an immediate restart.
        run_one(3'b111, 0, 5, 5, 5, 6, 1'b1, 0);
        check("t4_err_code",  64'(err_code),  64'd2);
        check("t4_err_stage", 64'(err_stage), 64'd0);
        check("t4_run_cycles", 64'(run_cycles), 64'd7);
        run_one(3'b011, 0, 3, 4, 5, -1, 1'b1, 1);
        check("t5_error",    64'(error),    64'd0);
        check("t5_err_code", 64'(err_code), 64'd0);

        // Asynchronous reset during stage 1 WAIT.
        plan(3'b111, 0, 5, 5, 5, -1);
        for (int c = 0; c < 10; c++) begin
            drive_cycle(c, 3'b111, 0, 1'b0);
            @(posedge clk); #1;
        end
        drive_cycle(10, 3'b111, 0, 1'b0);
        #2;
        check("pre_rst_busy", 64'(busy), 64'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_stage_start", 64'(stage_start), 64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        check("rst_done",        64'(done),        64'd0);
        check("rst_error",       64'(error),       64'd0);
        check("rst_err_code",    64'(err_code),    64'd0);
        check("rst_err_stage",   64'(err_stage),   64'd0);
        check("rst_cur_stage",   64'(cur_stage),   64'd0);
        check("rst_run_cycles",  64'(run_cycles),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_err = 1'b0; m_code = 2'd0; m_estage = 2'd0; m_run = 32'd0;
        set_idle();
        chk_en = 1'b1;
        @(posedge clk); #1;
        run_one(3'b111, 0, 5, 5, 5, -1, 1'b0, 1);
        check("t6_run_cycles", 64'(run_cycles), 64'd22);
        check("t6_error",      64'(error),      64'd0);

        // Randomized runs.
        for (int r = 0; r < 60; r++) begin
            logic [2:0] mk;
            int lim, l0, l1, l2, ab;
            mk  = 3'($urandom);
            lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 14));
            l0  = int'($urandom_range(1, 12));
            l1  = int'($urandom_range(1, 12));
            l2  = int'($urandom_range(1, 12));
            if (lim != 0) begin
                if ($urandom_range(0, 3) == 0) l0 = 0;
                if ($urandom_range(0, 3) == 0) l1 = 0;
                if ($urandom_range(0, 3) == 0) l2 = 0;
            end
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 45)) : -1;
            run_one(mk, lim, l0, l1, l2, ab, 1'b1, int'($urandom_range(0, 3)));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
